// File: rtl/definesPkg.sv
// definesPkg: shared types and defaults for the cache-to-MainMemory arbiter slice
package definesPkg;
  localparam int NUM_REQ_DEF = 2;
  localparam int MEM_RD_LAT_DEF = 1;
  localparam int PAGE_W = 1;
  localparam int CODE_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} Tarb_state;
  typedef enum logic [1:0] {INV, SHR, EXC, MOD} Tmesi_state;
  typedef logic [63:0] Tdata_sb;
  typedef struct packed {
    logic [PAGE_W-1:0] page_reference;
    logic [CODE_W-1:0] address_code;
  } Taddress;
endpackage

// File: rtl/main_memory.sv
// MainMemory: data+MESI store; read data appears MEM_RD_LAT cycles after addr is sampled
module MainMemory
  import definesPkg::*;
#(
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic       clk,
  input  Taddress    addr,
  input  Tdata_sb    wdata,
  input  logic       we,
  input  Tmesi_state mesi_state_in,
  output Tdata_sb    rdata,
  output Tmesi_state mesi_state_out
);
  localparam int DEPTH = 1 << $bits(Taddress);
  Tdata_sb    data_mem [DEPTH];
  Tmesi_state mesi_mem [DEPTH];
  Tdata_sb    rd_pipe [MEM_RD_LAT];
  Tmesi_state ms_pipe [MEM_RD_LAT];
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[addr] <= wdata;
      mesi_mem[addr] <= mesi_state_in;
    end
    rd_pipe[0] <= data_mem[addr];
    ms_pipe[0] <= mesi_mem[addr];
    for (int i = 1; i < MEM_RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      ms_pipe[i] <= ms_pipe[i-1];
    end
  end
  assign rdata = rd_pipe[MEM_RD_LAT-1];
  assign mesi_state_out = ms_pipe[MEM_RD_LAT-1];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching from the requester after the last winner
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    grant = '0;
    idx = last;
    j = '0;
    // walk farthest-first so the nearest requester after last overwrites
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last) + i) % N);
      if (req[j]) begin
        grant = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one MainMemory port among NUM_REQ cache requesters
module mem_arbiter
  import definesPkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic       [NUM_REQ-1:0]  req_valid,
  input  logic       [NUM_REQ-1:0]  req_we,
  input  Taddress    [NUM_REQ-1:0]  req_addr,
  input  Tdata_sb    [NUM_REQ-1:0]  req_wdata,
  input  Tmesi_state [NUM_REQ-1:0]  req_mesi,
  output logic       [NUM_REQ-1:0]  req_ready,
  output logic       [NUM_REQ-1:0]  rsp_valid,
  output Tdata_sb                   rsp_rdata,
  output Tmesi_state                rsp_mesi,
  output Taddress                   mem_addr,
  output Tdata_sb                   mem_wdata,
  output logic                      mem_we,
  output Tmesi_state                mem_mesi_in,
  input  Tdata_sb                   mem_rdata,
  input  Tmesi_state                mem_mesi_out,
  output logic                      busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = MEM_RD_LAT > 1 ? $clog2(MEM_RD_LAT) : 1;
  Tarb_state state_q, state_d;
  logic [IW-1:0] last_q, last_d, win_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant, last_oh, rsp_valid_q, rsp_valid_d;
  logic we_q, we_d;
  Taddress addr_q, addr_d;
  Tdata_sb wdata_q, wdata_d, rdata_q, rdata_d;
  Tmesi_state mesi_q, mesi_d, rmesi_q, rmesi_d;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req  (req_valid),
    .last (last_q),
    .grant(grant),
    .idx  (win_idx)
  );
  assign last_oh = NUM_REQ'(1) << last_q;
  // accept is combinational in IDLE so a read completes MEM_RD_LAT+2 cycles after it
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_mesi = rmesi_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign mem_mesi_in = mesi_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mesi_d = mesi_q;
    rdata_d = rdata_q;
    rmesi_d = rmesi_q;
    we_d = 1'b0;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = ISSUE;
        last_d = win_idx;
        we_d = req_we[win_idx];
        addr_d = req_addr[win_idx];
        wdata_d = req_wdata[win_idx];
        mesi_d = req_mesi[win_idx];
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d = CW'(MEM_RD_LAT - 1);
        rsp_valid_d = we_q ? last_oh : '0;
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        rsp_valid_d = last_oh;
        rdata_d = mem_rdata;
        rmesi_d = mem_mesi_out;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
      we_q <= 1'b0;
      rsp_valid_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      mesi_q <= INV;
      rdata_q <= '0;
      rmesi_q <= INV;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mesi_q <= mesi_d;
      rdata_q <= rdata_d;
      rmesi_q <= rmesi_d;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of cache-side requesters sharing MainMemory.
REQ-002 Parameter MEM_RD_LAT, default 1: cycles from the MainMemory sampling edge of addr to valid rdata/mesi_state_out.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  per-requester access request.
REQ-006 req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-007 req_addr  in  NUM_REQ x Taddress  Page_reference/Address_code.
REQ-008 req_wdata  in  NUM_REQ x Tdata_sb  write data.
REQ-009 req_mesi  in  NUM_REQ x Tmesi_state  state written with the data.
REQ-010 req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot or zero.
REQ-011 rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot or zero.
REQ-012 rsp_rdata  out  Tdata_sb  read data, shared by all requesters, valid with rsp_valid.
REQ-013 rsp_mesi  out  Tmesi_state  read MESI state, valid with rsp_valid.
REQ-014 mem_addr / mem_wdata / mem_we / mem_mesi_in  out  Taddress / Tdata_sb / 1 / Tmesi_state  drive MainMemory addr/wdata/we/mesi_state_in.
REQ-015 mem_rdata / mem_mesi_out  in  Tdata_sb / Tmesi_state  from MainMemory rdata/mesi_state_out.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if any req_valid is high, pick the winner round-robin, pulse req_ready[winner], latch its we/addr/wdata/mesi, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Round-robin: search starts at last_grant+1 mod NUM_REQ; after reset, requester 0 has highest priority.
REQ-020 ISSUE (one cycle): drive the latched request on mem_*.
  - mem_we = latched we.
  - Next state: WAIT for reads, RESP for writes.
REQ-021 WAIT SHALL last MEM_RD_LAT cycles (counter); on the last cycle, register mem_rdata/mem_mesi_out into rsp_rdata/rsp_mesi, then go to RESP.
REQ-022 RESP (one cycle): pulse rsp_valid[winner], then go to IDLE.
  - Write: rsp_rdata/rsp_mesi hold their previous values.
REQ-023 Latency from the req_ready cycle to the rsp_valid cycle: read = MEM_RD_LAT+2, write = 2.
  - The next accept is possible at the earliest in the cycle after RESP.
REQ-024 mem_we SHALL be 1 only in an ISSUE cycle of a write.
  - mem_addr/mem_wdata/mem_mesi_in hold their last values outside ISSUE.
REQ-025 Requester obligations: keep payload stable while req_valid is high and until req_ready.
  - Withdrawing req_valid before req_ready is legal and SHALL issue no access.
REQ-026 Requests arriving while busy SHALL be held off (req_ready stays 0); none are dropped or queued internally.
REQ-027 Address fields SHALL pass through unmodified, including Address_code 0xFF and the highest Page_reference; the block does no address wrap or increment.

Reset
REQ-028 Reset SHALL force the following asynchronously, including mid-transaction:
  - FSM to IDLE, last_grant to NUM_REQ-1.
  - req_ready, rsp_valid, mem_we, busy to 0.
  - mem_addr, mem_wdata, rsp_rdata to 0.
  - mem_mesi_in, rsp_mesi to INV.
REQ-029 A transaction interrupted by reset SHALL never produce rsp_valid; the requester re-requests.

Structure
REQ-030 The Tarb_state enum (IDLE, ISSUE, WAIT, RESP) and the constants NUM_REQ_DEF and MEM_RD_LAT_DEF SHALL live in definesPkg.
REQ-031 Winner selection SHALL be a sub-module rr_arbiter (request vector + last_grant -> one-hot grant); the pointer register stays in mem_arbiter.
REQ-032 The bench SHALL instantiate mem_arbiter together with MainMemory.

Verification
REQ-033 Write through requester 1: page 1, addr 0xFF, data 0xDEADBEEF_CAFEF00D, INV.
  - Required: req_ready[1] pulse; mem_we high exactly 1 cycle; rsp_valid[1] 2 cycles after the accept.
REQ-034 Read back the same location via requester 0.
  - Required: rsp_valid[0] exactly MEM_RD_LAT+2 cycles after accept; rsp_rdata = 0xDEADBEEF_CAFEF00D; rsp_mesi = INV.
REQ-035 Both req_valid held high for 6 reads after reset.
  - Required: grant order 0,1,0,1,0,1; req_ready never two-hot.
REQ-036 Reset asserted during WAIT of a read.
  - Required: busy, mem_we and rsp_valid at 0 immediately; no rsp_valid afterwards; next simultaneous request granted to requester 0.
REQ-037 req_valid[1] raised while busy, then dropped before IDLE.
  - Required: no req_ready[1] and no memory access for requester 1.
REQ-038 Sweep writes then reads over page 0/1 addresses 0x00..0xFF, alternating requesters.
  - Required: every read matches its prior write, and no access is lost or duplicated.
